// File: rtl/sram_resp_pkg.sv
// sram_resp_pkg: shared widths, FSM state type and the boot program image
// used by the SLC-3 memory responder and its ROM sub-module.
package sram_resp_pkg;

    localparam int WORD_W     = 16;
    localparam int CPU_ADDR_W = 16;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        READ_WAIT,
        RD_HOLD
    } state_t;

    // Boot program image: the first few words hold the test program,
    // everything after them is zero.
    function automatic logic [WORD_W-1:0] rom_word(input logic [31:0] idx);
        logic [WORD_W-1:0] w;
        case (idx)
            32'd0:   w = 16'h5020;
            32'd1:   w = 16'h1025;
            32'd2:   w = 16'h0FFE;
            32'd3:   w = 16'h0000;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/init_rom.sv
// init_rom: combinational lookup of the boot image. Indices at or beyond
// INIT_WORDS return zero so the init pass also clears the rest of the RAM.
module init_rom
    import sram_resp_pkg::*;
#(
    parameter int INIT_WORDS = 32,
    parameter int IDX_W      = 10
) (
    input  logic [IDX_W-1:0]  idx_i,
    output logic [WORD_W-1:0] word_o
);

    logic [31:0] idxWide;

    // Table lookup; anything past the image length reads as zero.
    always_comb begin
        idxWide = 32'(idx_i);
        word_o  = '0;
        if (idxWide < $unsigned(INIT_WORDS)) begin
            word_o = rom_word(idxWide);
        end
    end

endmodule

// File: rtl/sram_responder.sv
// sram_responder: memory-side responder for the SLC-3 CPU. After each reset
// an init pass copies the boot image into the word-addressed RAM, then CPU
// writes are taken in IDLE and reads complete after a programmable latency.
module sram_responder
    import sram_resp_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int INIT_WORDS = 32,
    parameter int READ_LAT   = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  OE,
    input  logic                  WE,
    input  logic [CPU_ADDR_W-1:0] ADDR,
    input  logic [WORD_W-1:0]     Data_to_SRAM,
    output logic [WORD_W-1:0]     Data_from_SRAM,
    output logic                  Init_Done,
    output logic                  Busy
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam int                WAIT_W    = 3;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(READ_LAT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [WORD_W-1:0] ram [DEPTH];

    state_t            state_q;
    logic [ADDR_W-1:0] initCnt_q;
    logic [WAIT_W-1:0] waitCnt_q;
    logic [ADDR_W-1:0] rdAddr_q;
    logic [WORD_W-1:0] dout_q;
    logic              initDone_q;
    logic              busy_q;

    logic [ADDR_W-1:0] cpuAddr;
    logic [WORD_W-1:0] romWord;
    logic              ramWrEn;
    logic [ADDR_W-1:0] ramWrAddr;
    logic [WORD_W-1:0] ramWrData;
    logic [ADDR_W-1:0] rdSel;
    logic [WORD_W-1:0] rdData;

    // Upper MAR bits alias onto the RAM; they are deliberately dropped.
    assign cpuAddr = ADDR[ADDR_W-1:0];

    generate
        if (ADDR_W < CPU_ADDR_W) begin : gUnusedAddr
            logic unusedAddrHi;
            assign unusedAddrHi = ^ADDR[CPU_ADDR_W-1:ADDR_W];
        end
    endgenerate

    init_rom #(
        .INIT_WORDS(INIT_WORDS),
        .IDX_W     (ADDR_W)
    ) uInitRom (
        .idx_i (initCnt_q),
        .word_o(romWord)
    );

    // Single RAM write port: the init walker owns it during INIT, the CPU
    // owns it in IDLE. Nothing is written while reset is held.
    always_comb begin
        ramWrEn   = 1'b0;
        ramWrAddr = cpuAddr;
        ramWrData = Data_to_SRAM;
        if (!Reset) begin
            if (state_q == INIT) begin
                ramWrEn   = 1'b1;
                ramWrAddr = initCnt_q;
                ramWrData = romWord;
            end else if (state_q == IDLE && WE) begin
                ramWrEn = 1'b1;
            end
        end
    end

    // RAM storage, left unreset so it can map onto block memory.
    always_ff @(posedge Clk) begin
        if (ramWrEn) begin
            ram[ramWrAddr] <= ramWrData;
        end
    end

    // Read address: the live CPU address for a single-cycle read out of IDLE,
    // otherwise the address latched when the read started.
    always_comb begin
        rdSel  = (state_q == IDLE) ? cpuAddr : rdAddr_q;
        rdData = ram[rdSel];
    end

    // Control FSM with registered outputs; reset aborts init or a read.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= INIT;
            initCnt_q  <= '0;
            waitCnt_q  <= '0;
            rdAddr_q   <= '0;
            dout_q     <= '0;
            initDone_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            case (state_q)
                INIT: begin
                    initCnt_q <= initCnt_q + 1'b1;
                    if (initCnt_q == LAST_ADDR) begin
                        state_q    <= IDLE;
                        initDone_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                IDLE: begin
                    if (!WE && OE) begin
                        if (READ_LAT == 1) begin
                            dout_q <= rdData;
                        end else begin
                            rdAddr_q  <= cpuAddr;
                            waitCnt_q <= WAIT_LOAD;
                            state_q   <= READ_WAIT;
                            busy_q    <= 1'b1;
                        end
                    end
                end
                READ_WAIT: begin
                    if (!OE) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (waitCnt_q == '0) begin
                        dout_q  <= rdData;
                        state_q <= RD_HOLD;
                        busy_q  <= 1'b0;
                    end else begin
                        waitCnt_q <= waitCnt_q - 1'b1;
                    end
                end
                RD_HOLD: begin
                    if (!OE) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    assign Data_from_SRAM = dout_q;
    assign Init_Done      = initDone_q;
    assign Busy           = busy_q;

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the SLC-3 CPU memory interface. Consumes the CPU's registered MAR address, MDR write data and OE/WE strobes; returns read data destined for the MDR input path.
- Holds a word-addressed on-chip RAM.
- After every reset, an init FSM copies a program image from a ROM sub-module into RAM before any CPU access is served.
- Read latency is parameterised so the ISDU's multi-cycle memory states can be exercised.

Parameters:
- ADDR_W, 10: RAM address width; depth = 2**ADDR_W words of 16 bits.
- INIT_WORDS, 32: number of leading words loaded from the ROM image. Addresses at or above INIT_WORDS are cleared to 0x0000.
- READ_LAT, 2: cycles from OE sampled high to read data valid; legal range 1..7.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- OE  in  1  CPU read strobe, active-high, level-held by the ISDU for the whole read state sequence.
- WE  in  1  CPU write strobe, active-high.
- ADDR  in  16  word address from MAR; only ADDR[ADDR_W-1:0] is used, upper bits ignored (aliasing/wrap).
- Data_to_SRAM  in  16  write data from MDR.
- Data_from_SRAM  out  16  registered read data to the CPU.
- Init_Done  out  1  high once the RAM image is loaded; low during init.
- Busy  out  1  high during init and while a read is in its wait cycles.

Behaviour:
- Reset (async assert, sync to next edge on release):
  - state=INIT, init counter=0, read-wait counter=0.
  - Data_from_SRAM=0x0000, Init_Done=0, Busy=1.
  - Reset asserted in any state, including mid-init or mid-read, aborts immediately. RAM contents are don't-care until re-initialised.
- INIT:
  - Each cycle writes ram[cnt] = (cnt < INIT_WORDS) ? rom_word(cnt) : 0x0000, then cnt++.
  - After writing address 2**ADDR_W-1: go to IDLE, Init_Done=1, Busy=0. Init takes exactly 2**ADDR_W cycles.
  - OE/WE are ignored during INIT; no RAM write from the CPU side; Data_from_SRAM stays 0x0000.
- IDLE:
  - WE=1: ram[ADDR[ADDR_W-1:0]] <= Data_to_SRAM on this edge; stay in IDLE.
  - WE has priority: if OE=1 and WE=1 together, the write happens and no read is started.
  - OE=1, WE=0: latch the address, load wait counter = READ_LAT-1, go to READ_WAIT. With READ_LAT=1, go straight to read completion: data registered on the same edge, stay in IDLE.
  - Neither strobe: hold Data_from_SRAM.
- READ_WAIT:
  - Busy=1; counter decrements each cycle.
  - At counter 0: Data_from_SRAM <= ram[latched addr], go to RD_HOLD.
  - If OE drops early: abort to IDLE, Data_from_SRAM unchanged.
  - WE asserted in READ_WAIT is ignored (CPU protocol never does this).
- RD_HOLD:
  - Busy=0; Data_from_SRAM holds its value.
  - Stays while OE=1, so a long-held OE gives a single access rather than repeated ones. Returns to IDLE when OE=0.
  - A new read requires OE to deassert for at least one cycle.
- Data_from_SRAM changes only on read completion or reset; writes never update it.
- Read-after-write to the same address returns the new data.

Decomposition:
- Package sram_resp_pkg:
  - state enum {INIT, IDLE, READ_WAIT, RD_HOLD}.
  - WORD_W=16.
  - Function rom_word(idx) returning the program image; idx 0..3 = 0x5020, 0x1025, 0x0FFE, 0x0000, others 0x0000 up to INIT_WORDS.
- Sub-module init_rom: combinational table lookup by index, wraps rom_word, parameterised by INIT_WORDS. RAM array and FSM live in sram_responder.

Test Plan:
- Reset, then run 2**ADDR_W cycles -> Init_Done rises exactly on cycle 1024 (ADDR_W=10); Busy falls the same cycle; Data_from_SRAM=0x0000 throughout.
- After init, OE=1 ADDR=0x0001 held 4 cycles (READ_LAT=2) -> Data_from_SRAM=0x1025 two edges after OE sampled; value held, no re-read while OE stays high.
- WE=1 ADDR=0x0040 Data_to_SRAM=0xBEEF one cycle, then OE read of 0x0040 -> 0xBEEF. Read of 0x0440 (alias) -> 0xBEEF. Read of 0x0041 -> 0x0000.
- OE=1 and WE=1 together, ADDR=0x0002, data 0x1234 -> ram[2]=0x1234, Data_from_SRAM unchanged, Busy stays 0. Subsequent read -> 0x1234.
- Reset pulsed mid-READ_WAIT and again at init cnt=500 -> outputs return to reset values immediately. Full 1024-cycle init reruns; ram[0x40] reads 0x0000 afterwards.
- OE pulsed 1 cycle with READ_LAT=3 -> read aborted, Data_from_SRAM keeps its previous value, FSM back in IDLE next cycle.
